vec_sweep_ctrl: RTL

Sequencer for the 5-input combinational `test_04` datapath. It drives the `{a,b,c,d,e}` operand bus through a programmed range of vectors and waits a configurable settle time per vector. It then samples `y`, accumulates a ones-count and, optionally, a signature. This lets the function be swept on-chip, or from a bench, without hand-written stimulus.

---
 rtl/vec_sweep_pkg.sv | 20 ++
 rtl/vec_sweep_ctrl_if.sv | 29 ++
 rtl/vec_sweep_misr.sv | 26 ++
 rtl/vec_sweep_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/vec_sweep_pkg.sv
// vec_sweep_pkg: shared types and constants for the vec_sweep_ctrl sequencer.
package vec_sweep_pkg;

  // operand bus width, {a,b,c,d,e}
  localparam int VEC_W = 5;
  // ones counter covers 0..32
  localparam int ONES_W = 6;
  // settle counter covers SETTLE 0..15
  localparam int CNT_W = 4;

  // MISR feedback taps x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3
  localparam logic [7:0] MISR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

endpackage

// File: rtl/vec_sweep_ctrl_if.sv
// vec_sweep_ctrl_if: operand/result bus between the sweep controller and
// whoever starts sweeps and supplies the datapath result.
interface vec_sweep_ctrl_if #(parameter int SIG_W = 8);
  import vec_sweep_pkg::*;

  logic                start;
  logic                hold;
  logic [VEC_W-1:0]    first;
  logic [VEC_W-1:0]    last;
  logic [VEC_W-1:0]    vec;
  logic                y_in;
  logic                busy;
  logic                done;
  logic [ONES_W-1:0]   ones_cnt;
  logic [SIG_W-1:0]    sig;

  // master: drives sweeps and returns y_in
  modport master (
    output start, hold, first, last, y_in,
    input  vec, busy, done, ones_cnt, sig
  );

  // slave: the sweep controller
  modport slave (
    input  start, hold, first, last, y_in,
    output vec, busy, done, ones_cnt, sig
  );

endinterface

// File: rtl/vec_sweep_misr.sv
// vec_sweep_misr: serial-input signature register. Shifts left, feeding the
// XOR of the tapped bits and the serial input into bit 0.
module vec_sweep_misr #(
  parameter int SIG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);
  import vec_sweep_pkg::*;

  localparam logic [SIG_W-1:0] TAPS = SIG_W'(MISR_TAPS);

  // signature state: cleared on reset or sweep start, shifted on each sample
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], (^(sig & TAPS)) ^ din};
    end
  end

endmodule

// File: rtl/vec_sweep_ctrl.sv
// vec_sweep_ctrl: steps the test_04 operand bus from first to last (mod 32),
// waits SETTLE cycles per vector, then samples y_in into a ones-count and,
// when VEC_SWEEP_MISR_EN is defined, a MISR signature (otherwise sig is 0).
module vec_sweep_ctrl #(
  parameter int SETTLE = 1,
  parameter int SIG_W  = 8
) (
  input logic             clk,
  input logic             rst,
  vec_sweep_ctrl_if.slave bus
);
  import vec_sweep_pkg::*;

  // last settle count before moving to SAMPLE; unused when SETTLE is 0
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  // state entered after a vector is applied
  localparam state_t WAIT_ST = (SETTLE == 0) ? SAMPLE : vec_sweep_pkg::SETTLE;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ONES_W-1:0]  ones_q;
  logic               clr;   // sweep accepted: clear accumulators
  logic               smp;   // unheld SAMPLE cycle: take a sample

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ones counter: cleared on start, bumped by y_in on each taken sample
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ones_q <= '0;
    end else if (smp) begin
      ones_q <= ones_q + ONES_W'(bus.y_in);
    end
  end

  // next-state and control; hold freezes everything outside IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    smp     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          last_d  = bus.last;
          vec_d   = bus.first;
          cnt_d   = '0;
          busy_d  = 1'b1;
          clr     = 1'b1;
          state_d = WAIT_ST;
        end
      end
      vec_sweep_pkg::SETTLE: begin
        if (!bus.hold) begin
          if (cnt_q == SET_LAST) begin
            cnt_d   = '0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SAMPLE: begin
        if (!bus.hold) begin
          smp = 1'b1;
          if (vec_q == last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            state_d = WAIT_ST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.vec      = vec_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ones_cnt = ones_q;

`ifdef VEC_SWEEP_MISR_EN
  logic [SIG_W-1:0] sig_w;

  vec_sweep_misr #(.SIG_W(SIG_W)) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (smp),
    .din (bus.y_in),
    .sig (sig_w)
  );

  assign bus.sig = sig_w;
`else
  assign bus.sig = '0;
`endif

endmodule
